// File: rtl/fpio_pkg.sv
// Shared types and constants for the multi-lane FPIO transmitter.
package fpio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        STALL,
        GAP
    } fpio_tx_state_e;

    localparam int FPIO_MIN_DIV = 2;

endpackage

// File: rtl/fpio_fifo.sv
// Synchronous word FIFO with first-word fall-through read data and occupancy count.
// Pushes while full and pops while empty are ignored.
module fpio_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
        else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fpio_tx_lanes.sv
// Multi-lane FPIO transmitter: FIFO-buffered words serialised MSB beat first with a forwarded strobe.
// Optional FPIO_TX_PARITY_EN adds a registered per-beat parity output pio_par_o.
module fpio_tx_lanes
    import fpio_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DIV_WIDTH-1:0]          divisor,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WORD_WIDTH-1:0]         s_data,
    input  logic                          s_last,
    output logic                          pio_clk_o,
    output logic [DATA_WIDTH-1:0]         pio_dat_o,
`ifdef FPIO_TX_PARITY_EN
    output logic                          pio_par_o,
`endif
    output logic                          pio_frm_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          underrun_o
);

    localparam int BEATS = WORD_WIDTH / DATA_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    fpio_tx_state_e          state_q, state_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [DIV_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]    per_q, per_d;
    logic [WORD_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    last_q, last_d;
    logic                    pio_clk_q, pio_clk_d;
    logic [DATA_WIDTH-1:0]   pio_dat_q, pio_dat_d;
    logic                    pio_frm_q, pio_frm_d;
    logic                    underrun_q, underrun_d;

    logic [WORD_WIDTH:0]     fifo_rdata;
    logic                    fifo_pop, fifo_full, fifo_empty, load;
    logic [DIV_WIDTH-1:0]    per_in;

    fpio_fifo #(
        .WIDTH (WORD_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .wdata ({s_last, s_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    assign s_ready = !fifo_full;
    assign per_in  = (divisor < DIV_WIDTH'(FPIO_MIN_DIV)) ? DIV_WIDTH'(FPIO_MIN_DIV) : divisor;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        shreg_d  = shreg_q;
        last_d   = last_q;
        load     = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE:  if (en && !fifo_empty) load = 1'b1;
            SHIFT: begin
                if (cnt_q == per_q - DIV_WIDTH'(1)) begin
                    if (beat_q == BW'(BEATS - 1)) begin
                        if (last_q) begin
                            state_d = GAP;
                            cnt_d   = '0;
                        end else if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = STALL;
                        end
                    end else begin
                        beat_d  = beat_q + BW'(1);
                        cnt_d   = '0;
                        shreg_d = shreg_q << DATA_WIDTH;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            STALL: if (!fifo_empty) load = 1'b1;
            GAP: begin
                if (cnt_q == per_q - DIV_WIDTH'(1)) state_d = IDLE;
                else                                cnt_d   = cnt_q + DIV_WIDTH'(1);
            end
            default: state_d = IDLE;
        endcase

        // Every word load (from IDLE, STALL or back-to-back) restarts the period latch.
        if (load) begin
            fifo_pop = 1'b1;
            state_d  = SHIFT;
            beat_d   = '0;
            cnt_d    = '0;
            per_d    = per_in;
            shreg_d  = fifo_rdata[WORD_WIDTH-1:0];
            last_d   = fifo_rdata[WORD_WIDTH];
        end

        // Outputs are registered from next-state values so they line up with the counters.
        pio_frm_d  = (state_d == SHIFT) || (state_d == STALL);
        pio_clk_d  = (state_d == SHIFT) && (cnt_d >= (per_d >> 1));
        pio_dat_d  = '0;
        if (state_d == SHIFT)      pio_dat_d = shreg_d[WORD_WIDTH-1 -: DATA_WIDTH];
        else if (state_d == STALL) pio_dat_d = pio_dat_q;
        underrun_d = (state_q == SHIFT) && (state_d == STALL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            cnt_q      <= '0;
            per_q      <= '0;
            shreg_q    <= '0;
            last_q     <= 1'b0;
            pio_clk_q  <= 1'b0;
            pio_dat_q  <= '0;
            pio_frm_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            per_q      <= per_d;
            shreg_q    <= shreg_d;
            last_q     <= last_d;
            pio_clk_q  <= pio_clk_d;
            pio_dat_q  <= pio_dat_d;
            pio_frm_q  <= pio_frm_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef FPIO_TX_PARITY_EN
    logic par_q, par_d;

    // Lane data is zero outside a frame, so the XOR is zero there too.
    always_comb begin
        par_d = ^pio_dat_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= par_d;
    end

    assign pio_par_o = par_q;
`endif

    assign pio_clk_o  = pio_clk_q;
    assign pio_dat_o  = pio_dat_q;
    assign pio_frm_o  = pio_frm_q;
    assign underrun_o = underrun_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_fpio_tx_lanes.sv
// Directed bench for fpio_tx_lanes (DW=4, WW=16, depth 4) with hand-computed expected waveforms.
module tb_fpio_tx_lanes;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] divisor;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        pio_clk_o;
    logic [3:0]  pio_dat_o;
    logic        pio_frm_o;
    logic        busy_o;
    logic [2:0]  level_o;
    logic        underrun_o;
`ifdef FPIO_TX_PARITY_EN
    logic        pio_par_o;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fpio_tx_lanes #(
        .DATA_WIDTH (4),
        .WORD_WIDTH (16),
        .FIFO_DEPTH (4),
        .DIV_WIDTH  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .divisor    (divisor),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .pio_clk_o  (pio_clk_o),
        .pio_dat_o  (pio_dat_o),
`ifdef FPIO_TX_PARITY_EN
        .pio_par_o  (pio_par_o),
`endif
        .pio_frm_o  (pio_frm_o),
        .busy_o     (busy_o),
        .level_o    (level_o),
        .underrun_o (underrun_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Returns one tick after the handshake edge.
    task automatic push(input logic [15:0] d, input logic l);
        bit done = 0;
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = d; s_last = l;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        s_valid = 1'b0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    // Call at the negedge of the first beat cycle; leaves at the negedge after the last beat.
    task automatic expect_beats(input logic [127:0] bits, input int nb, input int p);
        logic [3:0] nib;
        for (int i = 0; i < nb * p; i++) begin
            nib = bits[(nb - 1 - i / p) * 4 +: 4];
            chk("dat", pio_dat_o, nib);
            chk("sclk", pio_clk_o, ((i % p) >= (p / 2)) ? 1 : 0);
            chk("frm", pio_frm_o, 1);
            chk("undr", underrun_o, 0);
`ifdef FPIO_TX_PARITY_EN
            chk("par", pio_par_o, ^nib);
`endif
            @(negedge clk);
        end
    endtask

    task automatic expect_gap(input int p);
        for (int i = 0; i < p; i++) begin
            chk("gap_frm", pio_frm_o, 0);
            chk("gap_clk", pio_clk_o, 0);
            chk("gap_dat", pio_dat_o, 0);
            chk("gap_busy", busy_o, 1);
            @(negedge clk);
        end
        chk("idle_busy", busy_o, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; divisor = 4; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        #2;
        chk("rst_frm", pio_frm_o, 0);
        chk("rst_clk", pio_clk_o, 0);
        chk("rst_dat", pio_dat_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_undr", underrun_o, 0);
        chk("rst_lvl", level_o, 0);
        @(posedge clk); #1; rst = 1'b0;
        chk("rst_rdy", s_ready, 1);

        // Single word, P=4: first beat two cycles after the handshake.
        en = 1'b1;
        push(16'hA5C3, 1'b1);
        @(negedge clk);
        chk("t1_frm_early", pio_frm_o, 0);
        chk("t1_lvl", level_o, 1);
        @(negedge clk);
        expect_beats(128'hA5C3, 4, 4);
        expect_gap(4);

        // Divisor floors and odd period.
        divisor = 0;
        push(16'h9ABC, 1'b1);
        @(negedge clk); @(negedge clk);
        expect_beats(128'h9ABC, 4, 2);
        expect_gap(2);
        divisor = 1;
        push(16'h4E21, 1'b1);
        @(negedge clk); @(negedge clk);
        expect_beats(128'h4E21, 4, 2);
        expect_gap(2);
        divisor = 5;
        push(16'h0F6D, 1'b1);
        @(negedge clk); @(negedge clk);
        expect_beats(128'h0F6D, 4, 5);
        expect_gap(5);

        // Two queued words go out back to back.
        divisor = 4; en = 1'b0;
        push(16'h1234, 1'b0);
        push(16'h5678, 1'b1);
        @(posedge clk); #1; en = 1'b1;
        @(negedge clk);
        chk("t3_frm_early", pio_frm_o, 0);
        @(negedge clk);
        expect_beats(128'h12345678, 8, 4);
        expect_gap(4);

        // Underrun: word without last, next word arrives late.
        divisor = 2;
        push(16'hBEEF, 1'b0);
        @(negedge clk); @(negedge clk);
        expect_beats(128'hBEEF, 4, 2);
        chk("st_undr1", underrun_o, 1);
        chk("st_frm", pio_frm_o, 1);
        chk("st_clk", pio_clk_o, 0);
        chk("st_dat", pio_dat_o, 4'hF);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("st_undr0", underrun_o, 0);
            chk("st_frm", pio_frm_o, 1);
            chk("st_clk", pio_clk_o, 0);
            chk("st_dat", pio_dat_o, 4'hF);
        end
        push(16'h1357, 1'b1);
        @(negedge clk);
        chk("st_hold_frm", pio_frm_o, 1);
        chk("st_hold_clk", pio_clk_o, 0);
        @(negedge clk);
        expect_beats(128'h1357, 4, 2);
        expect_gap(2);

        // FIFO fill with en low, then drain in order.
        en = 1'b0;
        push(16'h1111, 1'b0);
        push(16'h2222, 1'b0);
        push(16'h3333, 1'b0);
        push(16'h4444, 1'b0);
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = 16'h5555; s_last = 1'b1;
        @(negedge clk);
        chk("full_rdy", s_ready, 0);
        chk("full_lvl", level_o, 4);
        fork
            begin
                bit gone = 0;
                for (int j = 0; j < 40 && !gone; j++) begin
                    @(negedge clk);
                    if (s_ready) begin
                        @(posedge clk); #1;
                        s_valid = 1'b0;
                        gone = 1;
                    end
                end
                if (!gone) begin
                    s_valid = 1'b0;
                    chk("fifth_timeout", 0, 1);
                end
            end
        join_none
        @(posedge clk); #1; en = 1'b1;
        @(negedge clk);
        chk("pop_rdy_low", s_ready, 0);
        @(negedge clk);
        expect_beats(128'h11112222333344445555, 20, 2);
        expect_gap(2);
        chk("drain_lvl", level_o, 0);

        // Asynchronous reset mid-beat flushes everything.
        divisor = 4;
        push(16'hA5C3, 1'b0);
        push(16'h1111, 1'b1);
        @(negedge clk);
        chk("pre_rst_frm", pio_frm_o, 1);
        chk("pre_rst_lvl", level_o, 1);
        #1; rst = 1'b1; #1;
        chk("arst_frm", pio_frm_o, 0);
        chk("arst_dat", pio_dat_o, 0);
        chk("arst_clk", pio_clk_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_lvl", level_o, 0);
`ifdef FPIO_TX_PARITY_EN
        chk("arst_par", pio_par_o, 0);
`endif
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", s_ready, 1);
        chk("post_rst_lvl", level_o, 0);
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_frm", pio_frm_o, 0);
            chk("post_rst_busy", busy_o, 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
